pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and memory-stall controller for a five-stage pipeline: drives PC and
// buffer load enables, bubble flushes, a memory timeout latch and a stall counter.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             idex_load,
    output logic             exmem_load,
    output logic             memwb_load,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Bit order {pc, ifid, idex, exmem, memwb} and {ifid, idex, memwb}.
    localparam logic [4:0] LOADS_ALL  = 5'b11111;
    localparam logic [4:0] LOADS_NONE = 5'b00000;
    localparam logic [4:0] LOADS_LU   = 5'b00111;
    localparam logic [2:0] FL_NONE    = 3'b000;
    localparam logic [2:0] FL_BRANCH  = 3'b110;
    localparam logic [2:0] FL_LU      = 3'b010;
    localparam logic [2:0] FL_MEM     = 3'b001;
    localparam logic [2:0] FL_ALL     = 3'b111;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_error_q, mem_error_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic               load_use_s;
    logic [4:0]         run_loads_s, loads_s;
    logic [2:0]         run_flush_s, flush_s;

    assign load_use_s = ex_mem_read && (ex_dest != 5'd0) &&
                        ((ex_dest == id_rs) || (ex_dest == id_rt));

    // Normal-flow enables; a taken branch outranks a load-use stall.
    always_comb begin
        run_loads_s = LOADS_ALL;
        run_flush_s = FL_NONE;
        if (branch_taken) begin
            run_loads_s = LOADS_ALL;
            run_flush_s = FL_BRANCH;
        end else if (load_use_s) begin
            run_loads_s = LOADS_LU;
            run_flush_s = FL_LU;
        end else begin
            run_loads_s = LOADS_ALL;
            run_flush_s = FL_NONE;
        end
    end

    // FSM next state, wait counter and Mealy enable/flush outputs.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        loads_s     = LOADS_NONE;
        flush_s     = FL_NONE;
        if (reset) begin
            loads_s = LOADS_NONE;
            flush_s = FL_ALL;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_access && !mem_ready) begin
                        loads_s    = LOADS_NONE;
                        flush_s    = FL_MEM;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end else begin
                        loads_s = run_loads_s;
                        flush_s = run_flush_s;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        loads_s = LOADS_NONE;
                        flush_s = FL_MEM;
                        if (wait_cnt_q == TIMEOUT_V) begin
                            state_d     = ERROR;
                            mem_error_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end else begin
                        // EX was frozen, so hazards are judged afresh on exit.
                        loads_s    = run_loads_s;
                        flush_s    = run_flush_s;
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end
                end
                ERROR: begin
                    loads_s     = LOADS_NONE;
                    flush_s     = FL_NONE;
                    mem_error_d = 1'b1;
                end
                default: begin
                    loads_s     = LOADS_NONE;
                    flush_s     = FL_NONE;
                    state_d     = ERROR;
                    mem_error_d = 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        if (!loads_s[4] && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_error_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_error_q   <= mem_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = loads_s;
    assign {ifid_flush, idex_flush, memwb_flush}                   = flush_s;
    assign state       = state_q;
    assign mem_error   = mem_error_q;
    assign stall_count = stall_count_q;

endmodule
